// File: rtl/tlc_multiway_controller_if.sv
// Signal bundle between the multi-way traffic-light controller and its environment.
// master = controller side (consumes sensors, drives lights and debug); slave = board side.
interface tlc_multiway_controller_if #(
  parameter int NUM_DIR = 4,
  parameter int DIR_W   = 2,
  parameter int CNT_W   = 31
);
  // No handshake here: Sensor is a level sampled every rising edge, every output is a
  // registered Moore decode valid for the whole cycle.
  logic [NUM_DIR-1:0]   Sensor;
  logic [2*NUM_DIR-1:0] Signals;
  logic [1:0]           State;
  logic [DIR_W-1:0]     Active;
  logic [NUM_DIR-1:0]   Pending;
  logic                 RstCount;
  logic [CNT_W-1:0]     Count;

  modport master (
    input  Sensor,
    output Signals, State, Active, Pending, RstCount, Count
  );

  modport slave (
    output Sensor,
    input  Signals, State, Active, Pending, RstCount, Count
  );
endinterface

// File: rtl/tlc_multiway_controller.sv
// Demand-actuated round-robin traffic-light controller: main road (dir 0) rests green,
// side roads are served on latched requests, each changeover goes yellow then all-red.
module tlc_multiway_controller #(
  parameter int NUM_DIR      = 4,
  parameter int DIR_W        = 2,
  parameter int GREEN_TICKS  = 8,
  parameter int YELLOW_TICKS = 3,
  parameter int ALLRED_TICKS = 2,
  parameter int CNT_W        = 31
) (
  input logic Clk,
  input logic Rst,
  tlc_multiway_controller_if.master io_tlc
);

  typedef enum logic [1:0] {
    ST_ALLRED = 2'b00,
    ST_GREEN  = 2'b01,
    ST_YELLOW = 2'b10
  } state_t;

  localparam logic [1:0] LT_GREEN  = 2'b00;
  localparam logic [1:0] LT_YELLOW = 2'b01;
  localparam logic [1:0] LT_RED    = 2'b10;

  localparam logic [CNT_W-1:0] C_GREEN_LAST  = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] C_YELLOW_LAST = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] C_ALLRED_LAST = CNT_W'(ALLRED_TICKS - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [DIR_W-1:0]     r_active;
  logic [DIR_W-1:0]     r_next;
  logic [DIR_W-1:0]     w_sel;
  logic [NUM_DIR-1:0]   r_pending;
  logic [CNT_W-1:0]     r_count;
  logic [2*NUM_DIR-1:0] w_signals;
  logic                 w_trans;
  logic                 w_any_pend;
  logic                 w_enter_green;
  logic                 w_main_sat;
  logic                 w_unused_sensor0;

  // Direction 0 never requests; its sensor bit is deliberately dropped.
  assign w_unused_sensor0 = io_tlc.Sensor[0];

  assign w_any_pend    = |r_pending[NUM_DIR-1:1];
  assign w_trans       = (w_state_nxt != r_state);
  assign w_enter_green = (r_state == ST_ALLRED) && (w_state_nxt == ST_GREEN);
  assign w_main_sat    = (r_state == ST_GREEN) && (r_active == '0) &&
                         (r_count >= C_GREEN_LAST);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ALLRED: begin
        if (r_count == C_ALLRED_LAST) w_state_nxt = ST_GREEN;
      end
      ST_GREEN: begin
        if (r_active == '0) begin
          if ((r_count >= C_GREEN_LAST) && w_any_pend) w_state_nxt = ST_YELLOW;
        end else if (r_count == C_GREEN_LAST) begin
          w_state_nxt = ST_YELLOW;
        end
      end
      ST_YELLOW: begin
        if (r_count == C_YELLOW_LAST) w_state_nxt = ST_ALLRED;
      end
      default: w_state_nxt = ST_ALLRED;
    endcase
  end

  // Round-robin scan starting just after the current owner; falls back to the main road.
  always_comb begin
    logic found;
    int   idx;
    w_sel = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k < NUM_DIR; k++) begin
      idx = (int'(r_active) + k) % NUM_DIR;
      if (!found && (idx != 0) && r_pending[idx]) begin
        w_sel = DIR_W'(idx);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_state   <= ST_ALLRED;
      r_active  <= '0;
      r_next    <= '0;
      r_pending <= '0;
      r_count   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_enter_green) r_active <= r_next;
      // Target is frozen at the start of yellow; later requests wait for the next pass.
      if ((r_state == ST_GREEN) && (w_state_nxt == ST_YELLOW)) r_next <= w_sel;
      if (w_trans)          r_count <= '0;
      else if (!w_main_sat) r_count <= r_count + CNT_W'(1);
      r_pending[0] <= 1'b0;
      for (int i = 1; i < NUM_DIR; i++) begin
        if (((r_state == ST_GREEN) && (r_active == DIR_W'(i))) ||
            (w_enter_green && (r_next == DIR_W'(i))))
          r_pending[i] <= 1'b0;
        else if (io_tlc.Sensor[i])
          r_pending[i] <= 1'b1;
      end
    end
  end

  always_comb begin
    w_signals = '0;
    for (int i = 0; i < NUM_DIR; i++) begin
      w_signals[2*i +: 2] = LT_RED;
      if (r_active == DIR_W'(i)) begin
        if (r_state == ST_GREEN)       w_signals[2*i +: 2] = LT_GREEN;
        else if (r_state == ST_YELLOW) w_signals[2*i +: 2] = LT_YELLOW;
      end
    end
  end

  assign io_tlc.Signals  = w_signals;
  assign io_tlc.State    = r_state;
  assign io_tlc.Active   = r_active;
  assign io_tlc.Pending  = r_pending;
  assign io_tlc.Count    = r_count;
  assign io_tlc.RstCount = w_trans | ~Rst;

endmodule

// File: doc/tlc_multiway_controller.md
# tlc_multiway_controller

Parametrised, demand-actuated traffic-light controller for an intersection with `NUM_DIR` approaches. Direction 0 is the main road and rests in green. Every other direction is served only when its vehicle sensor has latched a request. Serving order is round-robin, and every change of right-of-way passes through yellow and an all-red clearance interval. The block replaces the fixed two-way highway/farm controller and sits between the board clock/reset and the light-driver outputs, with its state and counter exposed for the debug header.

## Interface
Parameters:
- `NUM_DIR`, 4, number of approaches; legal range 2..8.
- `DIR_W`, 2, index width; must satisfy 2^`DIR_W` >= `NUM_DIR`.
- `GREEN_TICKS`, 8, minimum green length in cycles; must be >= 1.
- `YELLOW_TICKS`, 3, yellow length in cycles; must be >= 1.
- `ALLRED_TICKS`, 2, all-red clearance length in cycles; must be >= 1.
- `CNT_W`, 31, counter width; must hold max(`GREEN_TICKS`, `YELLOW_TICKS`, `ALLRED_TICKS`) - 1.

Ports:
- `Clk`  in  1  single system clock; all state changes on its rising edge.
- `Rst`  in  1  reset, synchronous, active-low (0 = reset).
- `Sensor`  in  `NUM_DIR`  vehicle-present inputs, already synchronised; bit 0 is ignored.
- `Signals`  out  2*`NUM_DIR`  per-direction light. Direction i uses bits [2i+1:2i]. Encoding: 00 green, 01 yellow, 10 red; 11 is never driven.
- `State`  out  2  FSM state. Encoding: 00 ALLRED, 01 GREEN, 10 YELLOW.
- `Active`  out  `DIR_W`  direction currently owning right-of-way (green or yellow).
- `Pending`  out  `NUM_DIR`  latched request vector; bit 0 is always 0.
- `RstCount`  out  1  high on any cycle where `Count` clears on the next edge.
- `Count`  out  `CNT_W`  interval counter.

## Operation
- Outputs are decoded directly from the state, `Active` and counter registers (Moore behaviour). Nothing is combinational from `Sensor`.
- In ALLRED, every direction shows red. In GREEN and YELLOW, direction `Active` shows green or yellow and every other direction shows red.
- `Count` clears on every state transition and otherwise increments. In GREEN with `Active` = 0, it saturates at `GREEN_TICKS`-1 and does not wrap.
- Request latch, for each i in 1..`NUM_DIR`-1:
  - `Pending[i]` is set when `Sensor[i]` = 1.
  - `Pending[i]` is forced to 0 while State = GREEN and `Active` = i.
  - The clear also applies on the GREEN entry edge, so a request coinciding with the start of that direction's green is consumed.
- Next-direction selection: scan `Active`+1, `Active`+2, … modulo `NUM_DIR`, skipping 0, and take the first index with `Pending` set. If no index is found, the next direction is 0.
- FSM transitions:
  - ALLRED → GREEN when `Count` = `ALLRED_TICKS`-1. On this edge, `Active` is loaded from the `Next` register.
  - GREEN with `Active` = 0 → YELLOW when `Count` >= `GREEN_TICKS`-1 and any `Pending[1..]` is set. Otherwise the controller stays in GREEN indefinitely.
  - GREEN with `Active` ≠ 0 → YELLOW unconditionally when `Count` = `GREEN_TICKS`-1.
  - On GREEN → YELLOW, the selection result is stored in the `Next` register. Requests arriving later do not retarget it.
  - YELLOW → ALLRED when `Count` = `YELLOW_TICKS`-1.
- Reset (`Rst` = 0 at a rising edge) takes priority over everything:
  - State = ALLRED, `Active` = 0, `Next` = 0, `Pending` = 0, `Count` = 0.
  - `Signals` = all red, i.e. every field is 10.
  - Reset asserted mid-operation, including mid-yellow, has the same effect on the next edge.

## Timing
- The first green after reset release is direction 0, `ALLRED_TICKS` cycles after the first edge with `Rst` = 1.
- Sensor to latch: `Pending[i]` rises one edge after `Sensor[i]` is sampled high. A single-cycle pulse is sufficient.
- A non-main green lasts exactly `GREEN_TICKS` cycles.
- A main green lasts at least `GREEN_TICKS` cycles.
- Every changeover costs exactly `YELLOW_TICKS` + `ALLRED_TICKS` cycles.
- Worst-case wait for a request on direction i is bounded by one pass of the round-robin.
- `RstCount` = 1 on exactly the cycles where the next edge performs a state transition or reset.

## Test plan
Default parameters are used throughout: 4 directions, green 8, yellow 3, all-red 2.
- Reset: hold `Rst` = 0 for 3 cycles. `Signals` = 0xAA, State = 00, `Count` = 0. Release: 2 cycles later `Signals` = 0xA8 and State = 01.
- Idle main: no sensors for 100 cycles. `Signals` stays 0xA8 and `Count` saturates at 7.
- Single request:
  - Stimulus: 1-cycle pulse on `Sensor[2]` during cycle 3 of main green.
  - `Pending` = 0100.
  - Main green ends after cycle 8, then 0xA9 for 3 cycles, then 0xAA for 2 cycles.
  - 0x8A for 8 cycles, then yellow (0x9A) for 3 cycles and all-red for 2 cycles.
  - Return to 0xA8.
- Round-robin:
  - Stimulus: `Sensor[1]` and `Sensor[3]` pulse during main green; `Sensor[1]` pulses again during dir-3 green.
  - Service order: 1 → 3 → 1 → 0.
  - `Pending` clears per direction on each green entry.
- Own-green request: `Sensor[2]` held high only during dir-2 green. `Pending[2]` stays 0, and the controller goes 2 → 0 with no second service.
- Mid-yellow reset: `Rst` = 0 for 1 cycle during dir-1 yellow. Next edge gives `Signals` = 0xAA, `Pending` = 0, `Count` = 0; 2 cycles after release, dir 0 is green.
